// File: rtl/stack_program_feeder.sv
// stack_program_feeder
//   Holds a small writable program and issues it to the stack CPU one nibble
//   per cycle: opcode on the fetch cycle, then the operand held for the
//   opcode's execution length. The CPU is held in reset before each run.
//
// Optional build macro: FEEDER_LOOP_EN
//   When defined, finishing the last program word wraps pc to 0 and keeps
//   issuing; only HALT or rst_n ends the run. When undefined, the run ends
//   in DONE after the last word.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   load_en    write load_data to program word load_addr (IDLE/DONE only)
//   load_addr  program write address
//   load_data  {operand[7:4], opcode[3:0]}
//   start      single-cycle pulse: begin a run at address 0
//   cpu_in     registered nibble to the CPU's inbits
//   cpu_rst    registered active-high CPU reset
//   busy       run in progress
//   done       sticky: run ended at HALT or end of memory
//   pc         address of the instruction being issued
//   err        sticky: start or load rejected while busy
module stack_program_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [7:0]               load_data,
  input  logic                     start,
  output logic [3:0]               cpu_in,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     err
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
  localparam logic [3:0]  OpHalt = 4'hF;

  typedef enum logic [2:0] {StIdle, StCpuRst, StFetch, StExec, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [1:0]      exec_cnt_q, exec_cnt_d;
  logic [3:0]      cpu_in_q, cpu_in_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            mem_we;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      word_q, word_d;

  // Execution cycles per opcode (operand held on cpu_in for this many cycles).
  function automatic logic [1:0] exec_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_len = 2'd2;
      4'h9, 4'hA:                         exec_len = 2'd3;
      default:                            exec_len = 2'd1;
    endcase
  endfunction

  // Program memory is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

  assign word_q = mem[pc_q];
  assign word_d = mem[pc_d];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rst_cnt_d  = rst_cnt_q;
    exec_cnt_d = exec_cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        mem_we = load_en;
        if (start) begin
          state_d   = StCpuRst;
          pc_d      = '0;
          done_d    = 1'b0;
          rst_cnt_d = RCW'(1);
        end
      end
      StCpuRst: begin
        if (rst_cnt_q == RCW'(RST_CYCLES)) state_d = StFetch;
        else rst_cnt_d = rst_cnt_q + RCW'(1);
      end
      StFetch: begin
        if (word_q[3:0] == OpHalt) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d    = StExec;
          exec_cnt_d = 2'd1;
        end
      end
      StExec: begin
        if (exec_cnt_q == exec_len(word_q[3:0])) begin
          if (pc_q == AW'(DEPTH - 1)) begin
`ifdef FEEDER_LOOP_EN
            pc_d    = '0;
            state_d = StFetch;
`else
            state_d = StDone;
            done_d  = 1'b1;
`endif
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = StFetch;
          end
        end else begin
          exec_cnt_d = exec_cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Requests that arrive mid-run are dropped but remembered.
    if ((state_q == StCpuRst || state_q == StFetch || state_q == StExec) && (start || load_en))
      err_d = 1'b1;

    // Outputs are registered, so they are decoded from the state being entered.
    cpu_rst_d = (state_d == StIdle) || (state_d == StCpuRst);
    busy_d    = (state_d == StCpuRst) || (state_d == StFetch) || (state_d == StExec);
    cpu_in_d  = 4'h0;
    if (state_d == StFetch) cpu_in_d = (word_d[3:0] == OpHalt) ? 4'h0 : word_d[3:0];
    else if (state_d == StExec) cpu_in_d = word_d[7:4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      rst_cnt_q  <= '0;
      exec_cnt_q <= '0;
      cpu_in_q   <= 4'h0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rst_cnt_q  <= rst_cnt_d;
      exec_cnt_q <= exec_cnt_d;
      cpu_in_q   <= cpu_in_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cpu_in  = cpu_in_q;
  assign cpu_rst = cpu_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pc      = pc_q;
  assign err     = err_q;

endmodule

// File: tb/tb_stack_program_feeder.sv
module tb_stack_program_feeder;

  localparam int DEPTH = 16;
  localparam int RSTC  = 2;
  localparam int LOOP_CAP = 120;
  // Execution cycles per opcode 0..F (F = HALT, never executed).
  localparam int LEN [16] = '{1, 2, 2, 1, 1, 2, 2, 2, 2, 3, 3, 1, 1, 1, 1, 0};

  typedef struct packed {
    logic [3:0] in;
    logic       rst;
    logic       busy;
    logic       done;
    logic [3:0] pc;
  } trace_t;

  logic       clk = 1'b0;
  logic       rst_n, load_en, start;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [3:0] cpu_in;
  logic       cpu_rst, busy, done, err;
  logic [3:0] pc;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mdl_mem [DEPTH];
  trace_t     exp_q [$];
  logic [7:0] prog [DEPTH];

  stack_program_feeder #(.DEPTH(DEPTH), .RST_CYCLES(RSTC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .cpu_in    (cpu_in),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .pc        (pc),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic trace_t observed();
    trace_t t;
    t.in = cpu_in; t.rst = cpu_rst; t.busy = busy; t.done = done; t.pc = pc;
    return t;
  endfunction

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) load_word(4'(i), prog[i]);
  endtask

  // Expected per-cycle output trace of a run, straight from the program words.
  task automatic build_trace(output bit ends);
    int p;
    logic [3:0] op;
    bit stop;
    exp_q.delete();
    ends = 1'b0;
    stop = 1'b0;
    p = 0;
    for (int i = 0; i < RSTC; i++) exp_q.push_back('{4'h0, 1'b1, 1'b1, 1'b0, 4'h0});
    while (!stop && exp_q.size() < LOOP_CAP) begin
      op = mdl_mem[p][3:0];
      if (op == 4'hF) begin
        exp_q.push_back('{4'h0, 1'b0, 1'b1, 1'b0, 4'(p)});
        ends = 1'b1;
        stop = 1'b1;
      end else begin
        exp_q.push_back('{op, 1'b0, 1'b1, 1'b0, 4'(p)});
        for (int k = 0; k < LEN[op]; k++)
          exp_q.push_back('{mdl_mem[p][7:4], 1'b0, 1'b1, 1'b0, 4'(p)});
        if (p == DEPTH - 1) begin
`ifdef FEEDER_LOOP_EN
          p = 0;
`else
          ends = 1'b1;
          stop = 1'b1;
`endif
        end else begin
          p++;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; start = 1'b0; load_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Start a run and compare every cycle against the trace. inject_at pulses
  // start+load_en mid-run; abort_at drops rst_n after that trace cycle.
  task automatic run_prog(input string tag, input int inject_at, input int abort_at);
    bit ends;
    build_trace(ends);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_en = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s trace[%0d]", tag, i), 32'(observed()), 32'(exp_q[i]));
      if (i == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check({tag, " abort cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, " abort busy"}, 32'(busy), 32'd0);
        check({tag, " abort cpu_in"}, 32'(cpu_in), 32'd0);
        check({tag, " abort pc"}, 32'(pc), 32'd0);
        return;
      end
      if (i == inject_at) begin
        start = 1'b1; load_en = 1'b1; load_addr = 4'h0; load_data = ~mdl_mem[0];
      end
      tick();
      start = 1'b0;
      load_en = 1'b0;
    end
    if (ends) begin
      for (int i = 0; i < 2; i++)
        check($sformatf("%s done[%0d]", tag, i), 32'({cpu_in, cpu_rst, busy, done}),
              32'({4'h0, 1'b0, 1'b0, 1'b1}));
    end else begin
      check({tag, " still busy"}, 32'(busy), 32'd1);
      pulse_reset();
    end
  endtask

  initial begin
    bit halted;
    rst_n = 1'b0; load_en = 1'b0; start = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h0F;
    tick();
    tick();
    check("reset cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset cpu_in", 32'(cpu_in), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset pc", 32'(pc), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle cpu_rst", 32'(cpu_rst), 32'd1);

    // PUSH 3, OUTL, HALT
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'h0F;
    prog[0] = 8'h31; prog[1] = 8'h03;
    load_prog();
    run_prog("push_outl", -1, -1);

    // PUSH 2, PUSH 3, MULT, OUTL, POP, OUTH, HALT
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'h0F;
    prog[0] = 8'h21; prog[1] = 8'h31; prog[2] = 8'h09; prog[3] = 8'h03;
    prog[4] = 8'h02; prog[5] = 8'h04;
    load_prog();
    run_prog("mult", -1, -1);
    check("err clean run", 32'(err), 32'd0);

    // start + load while busy: rejected, err set, run undisturbed
    run_prog("inject", 5, -1);
    check("err after inject", 32'(err), 32'd1);
    run_prog("rerun mem intact", -1, -1);

    // Abort during MULT exec (trace index 10), then a clean rerun
    run_prog("abort", -1, 10);
    check("err cleared by reset", 32'(err), 32'd0);
    run_prog("after abort", -1, -1);

    // start and load in the same cycle from DONE: new word 0 is used
    load_en = 1'b1; load_addr = 4'h0; load_data = 8'h5A;
    mdl_mem[0] = 8'h5A;
    run_prog("load+start", -1, -1);
    check("err load+start", 32'(err), 32'd0);

    // Randomized programs with mostly rare HALTs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog[i] = 8'($urandom_range(0, 255));
        if (prog[i][3:0] == 4'hF && $urandom_range(0, 2) != 0) prog[i][3:0] = 4'h1;
      end
      load_prog();
      run_prog($sformatf("rand%0d", r), -1, -1);
    end

    // No HALT anywhere: end of memory (or wrap in loop builds)
    for (int i = 0; i < DEPTH; i++) prog[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 14))};
    load_prog();
    halted = 1'b0;
    run_prog("no_halt", -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
